// File: rtl/rfs_pio_pkg.sv
// -----------------------------------------------------------------------------
// rfs_pio_pkg
//   Shared constants and helpers for the RFS WiFi input PIO.
//
//   Contents
//     ADDR_*      word addresses of the slave registers
//     EDGE_*      values for the EDGE_TYPE parameter
//     IRQ_*       values for the IRQ_TYPE parameter
//     width_mask  32-bit mask with the low 'width' bits set
//     edge_detect edge vector for a given edge type, current and previous data
//
//   Optional feature macro used by the block: RFS_PIO_DEBOUNCE_EN
// -----------------------------------------------------------------------------
package rfs_pio_pkg;

   localparam int BUS_W = 32;

   // Register map (word addresses on the 2-bit slave address)
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Edge-capture sensitivity
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Interrupt source selection
   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

   // Mask of the low 'width' bits; a 64-bit intermediate keeps width=32 legal.
   function automatic logic [BUS_W-1:0] width_mask(input int width);
      logic [63:0] m;
      m = (64'd1 << width) - 64'd1;
      return m[BUS_W-1:0];
   endfunction

   // Per-bit edge vector of current data d against previous data p.
   function automatic logic [BUS_W-1:0] edge_detect(input logic [BUS_W-1:0] d,
                                                    input logic [BUS_W-1:0] p,
                                                    input int               edge_type);
      logic [BUS_W-1:0] e;
      if (edge_type == EDGE_RISE) begin
         e = d & ~p;
      end else if (edge_type == EDGE_FALL) begin
         e = ~d & p;
      end else begin
         e = d ^ p;
      end
      return e;
   endfunction

endpackage

// File: rtl/rfs_pio_debounce.sv
// -----------------------------------------------------------------------------
// rfs_pio_debounce
//   Single-bit debounce filter. The output follows the input only after the
//   input has differed from the output for DEBOUNCE_CYCLES consecutive clocks;
//   any cycle where the input equals the output restarts the count.
//   Instantiated once per in_port bit when RFS_PIO_DEBOUNCE_EN is defined.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable cycles required before dout changes (>= 1)
//
//   Ports
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     din      in   synchronised input bit
//     dout     out  filtered bit (registered)
// -----------------------------------------------------------------------------
module rfs_pio_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Count value reached on the last differing cycle before dout flips.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din != dout) begin
         if (cnt == CNT_LAST) begin
            dout <= din;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/rfs_wifi_pio_in_irq.sv
// -----------------------------------------------------------------------------
// rfs_wifi_pio_in_irq
//   Avalon-MM input PIO with edge capture and a single interrupt line for the
//   RFS WiFi system (switches and WiFi status inputs to the Nios II).
//
//   Parameters
//     WIDTH            in_port width, 1..32
//     SYNC_STAGES      synchroniser flops per bit, >= 2
//     EDGE_TYPE        EDGE_RISE / EDGE_FALL / EDGE_ANY
//     IRQ_TYPE         IRQ_LEVEL (data & mask) / IRQ_EDGE (edgecapture & mask)
//     DEBOUNCE_CYCLES  debounce length, used only when RFS_PIO_DEBOUNCE_EN is
//                      defined
//
//   Build option
//     RFS_PIO_DEBOUNCE_EN  defined: each bit passes through rfs_pio_debounce
//                          undefined: filtered data is the synchroniser output
//
//   Ports
//     clk         in   1      system clock
//     reset_n     in   1      asynchronous active-low reset
//     address     in   2      register select
//     chipselect  in   1      slave select
//     write_n     in   1      active-low write strobe
//     writedata   in   32     write data
//     readdata    out  32     registered read data
//     in_port     in   WIDTH  asynchronous external inputs
//     irq         out  1      registered interrupt request, active high
//
//   Register map
//     0 DATA     RO   filtered input value
//     1 reserved      reads 0, writes ignored
//     2 IRQMASK  RW   bits [WIDTH-1:0]
//     3 EDGECAP  R/W1C per-bit edge capture
//
//   Bus handshake: fixed-timing slave with no wait states. A write is accepted
//   in every cycle where chipselect=1 and write_n=0 and takes effect at that
//   clock edge. readdata is refreshed on every clock from the address of the
//   previous cycle regardless of chipselect, giving one cycle of read latency.
// -----------------------------------------------------------------------------
module rfs_wifi_pio_in_irq
   import rfs_pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0,
   parameter int IRQ_TYPE        = 0,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [BUS_W-1:0] WMASK = width_mask(WIDTH);
   localparam int               PCW   = $clog2(SYNC_STAGES + 1);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("rfs_wifi_pio_in_irq: WIDTH must be 1..32");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rfs_wifi_pio_in_irq: SYNC_STAGES must be >= 2");
   end
   if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
      $error("rfs_wifi_pio_in_irq: EDGE_TYPE must be 0..2");
   end
   if (IRQ_TYPE != IRQ_LEVEL && IRQ_TYPE != IRQ_EDGE) begin : g_bad_irq
      $error("rfs_wifi_pio_in_irq: IRQ_TYPE must be 0 or 1");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("rfs_wifi_pio_in_irq: DEBOUNCE_CYCLES must be >= 1");
   end

   // ---------------------------------------------------------------------
   // Input synchroniser
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Optional debounce filter
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] data_filt;

`ifdef RFS_PIO_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      rfs_pio_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (sync_out[i]),
         .dout    (data_filt[i])
      );
   end
`else
   assign data_filt = sync_out;
`endif

   // ---------------------------------------------------------------------
   // Priming: the synchroniser holds reset zeros for SYNC_STAGES cycles.
   // Until it has filled, prev simply tracks the data so the first real
   // sample is not mistaken for an edge.
   // ---------------------------------------------------------------------
   logic [PCW-1:0]   prime_cnt;
   logic             primed;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_cnt <= '0;
         primed    <= 1'b0;
         prev_q    <= '0;
      end else begin
         if (prime_cnt != PCW'(SYNC_STAGES)) begin
            prime_cnt <= prime_cnt + PCW'(1);
         end
         if (prime_cnt == PCW'(SYNC_STAGES)) begin
            primed <= 1'b1;
         end
         prev_q <= data_filt;
      end
   end

   // ---------------------------------------------------------------------
   // Edge detection and register bank. Mask and capture registers are kept
   // 32 bits wide with the bits above WIDTH forced to zero, so readback is
   // zero-extended without extra muxing.
   // ---------------------------------------------------------------------
   logic [BUS_W-1:0] data32;
   logic [BUS_W-1:0] prev32;
   logic [BUS_W-1:0] edges;
   logic             wr_en;
   logic [BUS_W-1:0] w1c;
   logic [BUS_W-1:0] irqmask_q;
   logic [BUS_W-1:0] edgecap_q;
   logic [BUS_W-1:0] rd_mux;
   logic             irq_next;

   assign data32 = 32'(data_filt);
   assign prev32 = 32'(prev_q);
   assign edges  = primed ? (edge_detect(data32, prev32, EDGE_TYPE) & WMASK) : '0;
   assign wr_en  = chipselect & ~write_n;
   assign w1c    = (wr_en && address == ADDR_EDGECAP) ? (writedata & WMASK) : '0;

   if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
      assign irq_next = |(edgecap_q & irqmask_q);
   end else begin : g_irq_level
      assign irq_next = |(data32 & irqmask_q);
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux = data32;
         ADDR_IRQMASK: rd_mux = irqmask_q;
         ADDR_EDGECAP: rd_mux = edgecap_q;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q <= '0;
         edgecap_q <= '0;
         readdata  <= '0;
         irq       <= 1'b0;
      end else begin
         if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_q <= writedata & WMASK;
         end
         // A new edge in the same cycle as its clear keeps the bit set.
         edgecap_q <= (edgecap_q & ~w1c) | edges;
         readdata  <= rd_mux;
         irq       <= irq_next;
      end
   end

endmodule
